// File: rtl/alu_packet_responder.sv
// Packet-driven ALU behind a byte stream: parses a 4-byte header, then echoes,
// accumulates add/mul operands, or drains. Signed divide is built only when ALU_DIV_EN is defined.
module alu_packet_responder #(
    parameter logic [7:0] OP_ECHO = 8'hEC,
    parameter logic [7:0] OP_ADD  = 8'h01,
    parameter logic [7:0] OP_MUL  = 8'h02,
    parameter logic [7:0] OP_DIV  = 8'h03
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] s_axis_tdata_i,
    input  logic       s_axis_tvalid_i,
    output logic       s_axis_tready_o,
    output logic [7:0] m_axis_tdata_o,
    output logic       m_axis_tvalid_o,
    input  logic       m_axis_tready_i,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        HDR_OP, HDR_RSV, HDR_LEN_L, HDR_LEN_H, PAYLOAD, DIVIDE, RESP, DRAIN
    } state_t;

    state_t      state;
    logic [7:0]  opcode;
    logic [7:0]  len_l;
    logic [15:0] rem;
    logic [1:0]  byte_idx;
    logic [31:0] opnd;
    logic [31:0] opnd_next;
    logic [31:0] acc;
    logic [2:0]  resp_idx;
    logic        rdy_en;
    logic        m_vld;
    logic [7:0]  m_data;
    logic        tready_c;
    logic        s_fire;
    logic        op_echo, op_add, op_mul, op_div, op_arith;

    // Payload byte count after the 4 header bytes; short lengths clamp to zero.
    function automatic logic [15:0] sat_payload(input logic [15:0] len);
        return (len < 16'd4) ? 16'd0 : len - 16'd4;
    endfunction

    assign op_echo  = (opcode == OP_ECHO);
    assign op_add   = (opcode == OP_ADD);
    assign op_mul   = (opcode == OP_MUL);
`ifdef ALU_DIV_EN
    assign op_div   = (opcode == OP_DIV);
`else
    assign op_div   = 1'b0;
`endif
    assign op_arith = op_add | op_mul | op_div;

    always_comb begin
        opnd_next = opnd;
        opnd_next[8*byte_idx +: 8] = s_axis_tdata_i;
    end

    // Echo stalls the input only while a byte is stuck in the output register.
    always_comb begin
        tready_c = 1'b1;
        case (state)
            DIVIDE, RESP: tready_c = 1'b0;
            PAYLOAD:      if (op_echo) tready_c = !(m_vld && !m_axis_tready_i);
            default:      tready_c = 1'b1;
        endcase
    end

    assign s_axis_tready_o = tready_c & rdy_en;
    assign s_fire          = s_axis_tvalid_i & s_axis_tready_o;
    assign m_axis_tdata_o  = m_data;
    assign m_axis_tvalid_o = m_vld;
    assign busy_o          = (state != HDR_OP);

`ifdef ALU_DIV_EN
    logic        first_op;
    logic [31:0] div_q, div_r, div_d;
    logic        div_neg, div_zero;
    logic [4:0]  div_cnt;
    logic [32:0] div_rs;
    logic        div_ge;
    logic [31:0] div_q_next, div_r_next;

    function automatic logic [31:0] abs32(input logic signed [31:0] v);
        return v[31] ? 32'(-v) : 32'(v);
    endfunction

    function automatic logic [31:0] apply_sign(input logic [31:0] mag, input logic neg);
        logic signed [31:0] s;
        s = signed'(mag);
        return neg ? 32'(-s) : mag;
    endfunction

    // One restoring step on magnitudes per cycle; sign is fixed up at the end.
    always_comb begin
        div_rs     = {div_r, div_q[31]};
        div_ge     = (div_rs >= {1'b0, div_d});
        div_r_next = div_ge ? (div_rs[31:0] - div_d) : div_rs[31:0];
        div_q_next = {div_q[30:0], div_ge};
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= HDR_OP;
            opcode   <= '0;
            len_l    <= '0;
            rem      <= '0;
            byte_idx <= '0;
            opnd     <= '0;
            acc      <= '0;
            resp_idx <= '0;
            rdy_en   <= 1'b0;
            m_vld    <= 1'b0;
            m_data   <= '0;
`ifdef ALU_DIV_EN
            first_op <= 1'b0;
            div_q    <= '0;
            div_r    <= '0;
            div_d    <= '0;
            div_neg  <= 1'b0;
            div_zero <= 1'b0;
            div_cnt  <= '0;
`endif
        end else begin
            rdy_en <= 1'b1;
            if (m_vld && m_axis_tready_i) m_vld <= 1'b0;
            case (state)
                HDR_OP: if (s_fire) begin
                    opcode   <= s_axis_tdata_i;
                    byte_idx <= '0;
                    resp_idx <= '0;
                    acc      <= (s_axis_tdata_i == OP_MUL) ? 32'd1 : 32'd0;
`ifdef ALU_DIV_EN
                    first_op <= 1'b1;
`endif
                    state    <= HDR_RSV;
                end
                HDR_RSV: if (s_fire) state <= HDR_LEN_L;
                HDR_LEN_L: if (s_fire) begin
                    len_l <= s_axis_tdata_i;
                    state <= HDR_LEN_H;
                end
                HDR_LEN_H: if (s_fire) begin
                    rem <= sat_payload({s_axis_tdata_i, len_l});
                    if (sat_payload({s_axis_tdata_i, len_l}) == 16'd0)
                        state <= op_arith ? RESP : HDR_OP;
                    else if (op_arith || op_echo)
                        state <= PAYLOAD;
                    else
                        state <= DRAIN;
                end
                PAYLOAD: if (s_fire) begin
                    rem <= rem - 16'd1;
                    if (op_echo) begin
                        m_data <= s_axis_tdata_i;
                        m_vld  <= 1'b1;
                        if (rem == 16'd1) state <= HDR_OP;
                    end else begin
                        opnd     <= opnd_next;
                        byte_idx <= byte_idx + 2'd1;
                        state    <= (rem == 16'd1) ? RESP : PAYLOAD;
                        if (byte_idx == 2'd3) begin
                            if (op_add) acc <= acc + opnd_next;
                            else if (op_mul) acc <= acc * opnd_next;
`ifdef ALU_DIV_EN
                            else if (op_div) begin
                                first_op <= 1'b0;
                                if (first_op) begin
                                    acc <= opnd_next;
                                end else begin
                                    div_q    <= abs32(acc);
                                    div_d    <= abs32(opnd_next);
                                    div_r    <= '0;
                                    div_neg  <= acc[31] ^ opnd_next[31];
                                    div_zero <= (opnd_next == 32'd0);
                                    div_cnt  <= '0;
                                    state    <= DIVIDE;
                                end
                            end
`endif
                        end
                    end
                end
`ifdef ALU_DIV_EN
                DIVIDE: begin
                    div_q   <= div_q_next;
                    div_r   <= div_r_next;
                    div_cnt <= div_cnt + 5'd1;
                    if (div_cnt == 5'd31) begin
                        acc   <= div_zero ? 32'hFFFF_FFFF : apply_sign(div_q_next, div_neg);
                        state <= (rem == 16'd0) ? RESP : PAYLOAD;
                    end
                end
`endif
                // Output register is refilled only when empty or being drained this cycle.
                RESP: if (!m_vld || m_axis_tready_i) begin
                    if (resp_idx == 3'd4) begin
                        m_vld    <= 1'b0;
                        resp_idx <= '0;
                        state    <= HDR_OP;
                    end else begin
                        m_data   <= acc[8*resp_idx[1:0] +: 8];
                        m_vld    <= 1'b1;
                        resp_idx <= resp_idx + 3'd1;
                    end
                end
                DRAIN: if (s_fire) begin
                    rem <= rem - 16'd1;
                    if (rem == 16'd1) state <= HDR_OP;
                end
                default: state <= HDR_OP;
            endcase
        end
    end

endmodule

// File: doc/alu_packet_responder.md
ALU_PACKET_RESPONDER -- requirements
Module: alu_packet_responder

Interface
REQ-001 SHALL have parameter OP_ECHO, default 8'hEC, echo opcode.
REQ-002 SHALL have parameter OP_ADD, default 8'h01, add opcode.
REQ-003 SHALL have parameter OP_MUL, default 8'h02, multiply opcode.
REQ-004 SHALL have parameter OP_DIV, default 8'h03, signed-divide opcode.
REQ-005 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port s_axis_tdata_i  input  8  request byte from UART receiver.
REQ-008 SHALL have port s_axis_tvalid_i  input  1  request byte valid.
REQ-009 SHALL have port s_axis_tready_o  output  1  request byte accepted when tvalid&tready.
REQ-010 SHALL have port m_axis_tdata_o  output  8  response byte to UART transmitter.
REQ-011 SHALL have port m_axis_tvalid_o  output  1  response byte valid.
REQ-012 SHALL have port m_axis_tready_i  input  1  transmitter accepts response byte.
REQ-013 SHALL have port busy_o  output  1  high whenever state is not HDR_OP.

Function
REQ-014 SHALL parse packets: byte0 opcode, byte1 reserved (ignored), byte2 length LSB, byte3 length MSB; length counts header plus payload.
REQ-015 SHALL use states HDR_OP, HDR_RSV, HDR_LEN_L, HDR_LEN_H, PAYLOAD, DIVIDE, RESP, DRAIN; each header byte advances one state.
REQ-016 SHALL compute payload count = length-4; length<4 treated as payload 0; payload 0 goes from HDR_LEN_H directly to RESP (arith) or HDR_OP (echo/unknown).
REQ-017 SHALL assemble payload as 32-bit operands, little-endian (first byte = bits 7:0); trailing 1-3 bytes of an incomplete operand discarded.
REQ-018 Add: acc = sum of operands mod 2^32; zero operands -> 0.
REQ-019 Mul: acc = low 32 bits of product of operands; zero operands -> 1.
REQ-020 Div: first operand loads acc; each later operand enters DIVIDE, 32-cycle iterative signed division, quotient truncated toward zero; divisor 0 -> acc = 32'hFFFFFFFF; zero operands -> 0.
REQ-021 s_axis_tready_o SHALL be low in DIVIDE and RESP, high in header/PAYLOAD/DRAIN except echo backpressure (REQ-023).
REQ-022 After last payload byte (and any DIVIDE), RESP SHALL emit 4 acc bytes LSB first, then return to HDR_OP.
REQ-023 Echo: each accepted payload byte appears on m_axis_tdata_o the next cycle with tvalid; s_axis_tready_o low while an echo byte is pending and m_axis_tready_i low.
REQ-024 m_axis_tdata_o SHALL stay stable while m_axis_tvalid_o high and m_axis_tready_i low; advance only on tvalid&tready.
REQ-025 Unknown opcode SHALL consume payload in DRAIN with no response.
REQ-026 Simultaneous last response byte handshake and s_axis_tvalid_i: new byte not accepted that cycle; accepted from HDR_OP next cycle.
REQ-027 Length 16'hFFFF SHALL be handled without counter wrap (17-bit or saturating count).

Reset
REQ-028 On rst_ni low (any cycle, mid-packet included): state HDR_OP, s_axis_tready_o 0 during reset then 1 first cycle after release, m_axis_tvalid_o 0, m_axis_tdata_o 0, busy_o 0, acc and counters 0; partial packet discarded.

Configuration
REQ-029 Macro ALU_DIV_EN defined: divide path and DIVIDE state present per REQ-020.
REQ-030 ALU_DIV_EN undefined: divider not synthesised; OP_DIV treated as unknown opcode (REQ-025).

Verification
REQ-031 Echo: EC 00 08 00 DE AD BE EF -> response DE AD BE EF, then idle.
REQ-032 Add: 01 00 10 00 + operands 5, 7, FFFFFFFF -> response 0B 00 00 00 (wrap).
REQ-033 Mul: 02 00 0C 00 + operands 00010000, 00010003 -> response 00 00 03 00 (low 32 bits 0x00030000).
REQ-034 Div (ALU_DIV_EN): operands -7, 2 -> FD FF FF FF; operands 9, 0 -> FF FF FF FF; without macro -> no response, next packet processed normally.
REQ-035 Backpressure: m_axis_tready_i low 20 cycles during RESP -> tdata/tvalid stable, no bytes lost or duplicated.
REQ-036 Reset asserted after 2 payload bytes of an add -> outputs at reset values; following echo packet answered correctly.
